reset_seq_ctrl: RTL
===================

Name: reset_seq_ctrl

Overview:
Sequences reset release across NUM_DOMAINS downstream blocks in a fixed order, low index first.
- One domain reset is released at a time; its ready acknowledge is awaited before the next release.
- Includes a software re-reset request and an acknowledge timeout with error reporting.
- Sits between the board/sim reset source and per-block reset inputs. Domain resets are active-high.

Parameters:
NUM_DOMAINS, 4, number of sequenced reset domains (>=1)
SYNC_STAGES, 2, flops in reset_n deassertion synchronizer (>=2)
HOLD_CYCLES, 4, cycles all domains stay in reset after synchronized release (>=1)
STAGE_DELAY, 3, cycles between ready[i] acknowledge and release of domain i+1 (>=1)
ACK_TIMEOUT, 8, max cycles to wait for domain_ready[i] (>=1)

Ports:
clk  in  1  single clock; all logic on posedge
reset_n  in  1  asynchronous, active-low reset
sw_reset_req  in  1  synchronous level; re-runs full sequence
domain_ready  in  NUM_DOMAINS  per-domain init-complete, synchronous to clk
domain_reset  out  NUM_DOMAINS  active-high reset per domain
seq_busy  out  1  sequence in progress
seq_done  out  1  all domains released and acknowledged
timeout_err  out  1  sticky acknowledge timeout
err_domain  out  IDX_W  index of timed-out domain; IDX_W = max(1, $clog2(NUM_DOMAINS))

Behaviour:
- reset_n low (async): domain_reset = all 1s immediately; seq_busy=1, seq_done=0, timeout_err=0, err_domain=0; FSM=HOLD, counters=0.
- reset_n rise goes through reset_sync; rst_sync goes high on the SYNC_STAGES-th posedge after the rise.
- States: HOLD, WAIT_ACK(i), DELAY(i), DONE, ERROR. Domain index i and one shared counter are sized for max(HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT).
- HOLD:
  - Counter stays 0 while rst_sync=0.
  - Otherwise it increments each cycle; on the HOLD_CYCLES-th such edge, domain_reset[0] falls and the FSM enters WAIT_ACK(0), counter=0.
- WAIT_ACK(i): each edge samples domain_ready[i].
  - Ready=1, i<N-1: enter DELAY(i).
  - Ready=1, i=N-1: enter DONE.
  - Ready=0 and counter==ACK_TIMEOUT-1: enter ERROR, timeout_err=1, err_domain=i.
  - Otherwise counter++.
- DELAY(i): after STAGE_DELAY edges, domain_reset[i+1] falls and the FSM enters WAIT_ACK(i+1).
- Spacing: releases are spaced exactly 1+STAGE_DELAY cycles apart when ready is already high.
- DONE: seq_done=1, seq_busy=0. Later drops of domain_ready are ignored.
- ERROR:
  - seq_busy=0, seq_done=0.
  - Released domains (indices <= err_domain) stay released; all others stay asserted.
  - Held until sw_reset_req or reset_n.
- domain_reset is monotone within a sequence: a bit never falls before all lower bits have fallen.
- sw_reset_req=1 sampled in any state, at the next edge:
  - domain_reset = all 1s; FSM=HOLD, counter=0.
  - seq_done=0, seq_busy=1, timeout_err=0, err_domain=0.
  - While held high, the FSM stays in HOLD with counter 0. The sequence restarts on the first edge it is low, with rst_sync already high.
  - Takes priority over every FSM transition in the same cycle.
- reset_n asserted mid-sequence: immediate all-assert. No partial state survives.
- All outputs are registered. domain_reset is reset-asserted asynchronously and released synchronously.

Decomposition:
- reset_seq_pkg: state enum (HOLD, WAIT_ACK, DELAY, DONE, ERROR) and a counter-width helper function.
- Sub-module reset_sync: SYNC_STAGES flop chain with async active-low clear and data input tied 1. It produces rst_sync and is reusable elsewhere.

Test Plan:
Defaults throughout; edge 1 is the first posedge after reset_n rises.
1. ready tied all 1s -> domain_reset[0..3] fall at edges 6, 10, 14, 18; seq_done=1 at edge 19; timeout_err stays 0.
2. domain_ready[1] held 0 -> domain_reset[1] falls at edge 10; timeout_err=1 and err_domain=1 at edge 18; domain_reset[3:2] stay 1; seq_busy=0.
3. From the ERROR state of test 2, pulse sw_reset_req for 1 cycle -> next edge domain_reset=4'b1111, timeout_err=0. With ready all 1s, domain_reset[0] falls 4 edges after the req-low edge.
4. reset_n low for 1 cycle at edge 12 of test 1 -> domain_reset=4'b1111 before the next edge; sequence replays the test 1 timing relative to the new rise.
5. domain_ready[2] rises 5 cycles after domain_reset[2] falls (timeout 8) -> no error; domain_reset[3] falls 1+STAGE_DELAY edges after the sampling edge.
6. sw_reset_req high in DONE for 10 cycles -> resets held asserted for all 10 cycles plus HOLD_CYCLES; seq_done=0 throughout.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_ACK,
    DELAY,
    DONE,
    ERROR
  } seq_state_e;

  // Domain index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold (largest interval - 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/reset_seq_ctrl_if.sv
// Control/status bundle between the reset sequencer and the blocks it releases.
interface reset_seq_ctrl_if #(
  parameter int unsigned NUM_DOMAINS = 4
);
  import reset_seq_pkg::*;

  localparam int unsigned IDX_W = idx_width(NUM_DOMAINS);

  logic                   sw_reset_req;
  logic [NUM_DOMAINS-1:0] domain_ready;
  logic [NUM_DOMAINS-1:0] domain_reset;
  logic                   seq_busy;
  logic                   seq_done;
  logic                   timeout_err;
  logic [IDX_W-1:0]       err_domain;

  modport master (
    input  sw_reset_req, domain_ready,
    output domain_reset, seq_busy, seq_done, timeout_err, err_domain
  );

  modport slave (
    output sw_reset_req, domain_ready,
    input  domain_reset, seq_busy, seq_done, timeout_err, err_domain
  );

endinterface

// File: rtl/reset_sync.sv
// Reset deassertion synchronizer: asserts asynchronously, releases after STAGES clocks.
module reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync
);

  logic [STAGES-1:0] sync_q;

  // Shift a constant 1 through the chain once rst_n is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], 1'b1};
  end

  assign rst_sync = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Releases per-domain resets in index order, one at a time, waiting for each ready.
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned STAGE_DELAY = 3,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  reset_seq_ctrl_if.master  bus
);

  localparam int unsigned IDX_W = idx_width(NUM_DOMAINS);
  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT);

  logic                   rst_sync;
  seq_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   busy;
  logic                   done;
  logic                   terr;
  logic [IDX_W-1:0]       edom;

  reset_sync #(
    .STAGES   (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (reset_n),
    .rst_sync (rst_sync)
  );

  // Sequencer FSM; software request overrides every transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      dom_rst <= '1;
      busy    <= 1'b1;
      done    <= 1'b0;
      terr    <= 1'b0;
      edom    <= '0;
    end else if (bus.sw_reset_req) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      dom_rst <= '1;
      busy    <= 1'b1;
      done    <= 1'b0;
      terr    <= 1'b0;
      edom    <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (rst_sync) begin
            if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              cnt        <= '0;
              idx        <= '0;
              dom_rst[0] <= 1'b0;
              state      <= WAIT_ACK;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        WAIT_ACK: begin
          if (bus.domain_ready[idx]) begin
            cnt <= '0;
            if (idx == IDX_W'(NUM_DOMAINS - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DELAY;
            end
          end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            cnt   <= '0;
            state <= ERROR;
            busy  <= 1'b0;
            terr  <= 1'b1;
            edom  <= idx;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DELAY: begin
          if (cnt == CNT_W'(STAGE_DELAY - 1)) begin
            cnt                       <= '0;
            idx                       <= idx + IDX_W'(1);
            dom_rst[idx + IDX_W'(1)]  <= 1'b0;
            state                     <= WAIT_ACK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE, ERROR: begin
          // Terminal until software request or board reset.
        end
        default: state <= HOLD;
      endcase
    end
  end

  assign bus.domain_reset = dom_rst;
  assign bus.seq_busy     = busy;
  assign bus.seq_done     = done;
  assign bus.timeout_err  = terr;
  assign bus.err_domain   = edom;

endmodule
